oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Sequences the OAM DMA transfer triggered by a CPU write to register 0xFF46.
- Copies 160 bytes from source page {XX,00h} into OAM 0xFE00-0xFE9F.
- Arbitrates the shared memory bus between the CPU datapath and the DMA engine.
- Sits between the CPU memory interface in top and the memory/PPU OAM ports.

Parameters:
- BYTE_CYCLES, 4, clocks per transferred byte (min 3); total transfer = 160*BYTE_CYCLES + 1 setup clock.
- OAM_BYTES, 160, number of bytes copied per transfer.

Ports:
- cpu_clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_re  in  1  CPU read strobe.
- cpu_we  in  1  CPU write strobe.
- cpu_rdata  out  8  read data returned to CPU; same cycle as mem_rdata, 1 clock after cpu_re.
- mem_addr  out  16  shared bus address.
- mem_wdata  out  8  shared bus write data.
- mem_re  out  1  shared bus read strobe.
- mem_we  out  1  shared bus write strobe.
- mem_rdata  in  8  shared bus read data, valid 1 clock after mem_re.
- oam_addr  out  8  OAM write index 0-159.
- oam_wdata  out  8  OAM write data.
- oam_we  out  1  OAM write strobe.
- dma_active  out  1  high while a transfer is in progress.

Behaviour:
- Reset values: all outputs 0 except cpu_rdata=FFh; state=IDLE; dma_reg=00h; byte index=0.
- Register 0xFF46 is owned by this block and never forwarded to mem. Write latches dma_reg and starts or restarts a transfer. Read returns dma_reg on the following clock.
- Source high byte: src_hi = dma_reg if dma_reg <= DFh, else dma_reg-20h (E0h-FFh map to echo WRAM C0h-DFh).
- FSM states: IDLE, SETUP, READ, WRITE, PAD.
  - IDLE -> SETUP on a FF46 write.
  - SETUP: 1 clock; dma_active goes high on entry; index=0.
  - READ: 1 clock; mem_addr={src_hi,index}, mem_re=1.
  - WRITE: 1 clock; oam_addr=index, oam_wdata=mem_rdata, oam_we=1.
  - PAD: BYTE_CYCLES-2 clocks. Then index++. If index==OAM_BYTES -> IDLE (dma_active low), else READ.
- First oam_we occurs 3 clocks after the FF46 write clock. dma_active stays high for exactly 1 + 160*BYTE_CYCLES clocks.
- Index never wraps past 159. oam_addr is always < A0h.
- FF46 write while active: restarts at SETUP with index=0 and the new dma_reg. An in-flight WRITE in that same clock still completes.
- CPU arbitration while dma_active (with DMA_BUS_LOCK_EN):
  - HRAM FF80-FFFE and FF46 pass through / are served normally.
  - All other CPU reads return FFh; all other CPU writes are dropped.
- Idle: CPU strobes, address and data pass straight to mem_* in the same clock (combinational). cpu_rdata=mem_rdata.
- cpu_re and cpu_we both asserted: write wins, no read issued.
- rst mid-transfer: next clock is IDLE with dma_active=0 and no further oam_we.

Optional Feature:
- Macro DMA_BUS_LOCK_EN.
- Defined: CPU is locked out of non-HRAM addresses during DMA, as above.
- Undefined: cycle-stealing mode.
  - CPU accesses always pass through with priority.
  - If the CPU asserts cpu_re/cpu_we in the clock the FSM would be in READ, the FSM holds in READ (no mem_re from DMA) until the bus is free. Timing and dma_active stretch accordingly.
  - WRITE and PAD are never stalled.

Test Plan:
- Reset then idle: cpu_re at 0x1234 -> mem_addr=1234h, mem_re=1 same clock; cpu_rdata=mem_rdata next clock; dma_active=0.
- Write C1h to FF46 with BYTE_CYCLES=4 -> reads C100h..C19Fh in order; oam_we at index 0..159 carrying the matching data; dma_active high exactly 641 clocks.
- Write FEh to FF46 -> source DE00h-DE9Fh. Read FF46 -> FEh.
- DMA_BUS_LOCK_EN, mid-transfer: CPU read of 8000h -> cpu_rdata=FFh, no mem_re from CPU. CPU write FF90h=5Ah passes through. CPU write C000h produces no mem_we.
- Mid-transfer write 80h to FF46 at index 50 -> index resets to 0, next reads from 8000h; 160 further oam_we issued.
- rst asserted at index 100 -> dma_active=0 next clock, no oam_we afterwards. Without DMA_BUS_LOCK_EN: CPU reads every clock for 10 clocks during READ -> DMA stalls 10 clocks, total active = 651.

Source files
------------

// File: rtl/oam_dma_controller.sv
// -----------------------------------------------------------------------------
// oam_dma_controller
//
// Sequences the OAM DMA transfer started by a CPU write to register 0xFF46 and
// arbitrates the shared memory bus between the CPU datapath and the DMA engine.
// Each transfer copies OAM_BYTES bytes from page {src_hi,00h} into OAM, taking
// one READ, one WRITE and BYTE_CYCLES-2 PAD clocks per byte after one SETUP
// clock.
//
// Build option:
//   DMA_BUS_LOCK_EN  defined   : CPU is locked out of everything except HRAM
//                                (FF80-FFFE) and FF46 while DMA is active.
//                    undefined : cycle stealing; CPU accesses always win the
//                                bus and the DMA holds in READ until it is free.
//
// Ports:
//   cpu_clk, rst                   clock, synchronous active-high reset
//   cpu_addr/cpu_wdata/cpu_re/we   CPU side of the memory interface
//   cpu_rdata                      read data, valid the clock after cpu_re
//   mem_addr/mem_wdata/mem_re/we   shared memory bus
//   mem_rdata                      shared bus read data, 1 clock after mem_re
//   oam_addr/oam_wdata/oam_we      OAM write port (index 0..OAM_BYTES-1)
//   dma_active                     high while a transfer is in progress
// -----------------------------------------------------------------------------
module oam_dma_controller #(
    parameter int BYTE_CYCLES = 4,   // clocks per byte, minimum 3
    parameter int OAM_BYTES   = 160
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_re,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int          PAD_W        = (BYTE_CYCLES > 3) ? $clog2(BYTE_CYCLES - 2) : 1;
    localparam logic [PAD_W-1:0] PAD_LOAD   = PAD_W'(BYTE_CYCLES - 3);
    localparam logic [7:0]       LAST_INDEX = 8'(OAM_BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_PAD} state_t;

    // Source of cpu_rdata in the clock after a CPU read.
    typedef enum logic [1:0] {RD_FF, RD_MEM, RD_REG} rd_sel_t;

    state_t           state, state_next;
    rd_sel_t          rd_sel, rd_sel_next;
    logic [7:0]       dma_reg;
    logic [7:0]       index;
    logic [PAD_W-1:0] pad_cnt;
    logic [7:0]       src_hi;

    logic reg_hit, reg_wr, reg_rd;
    logic cpu_allowed, cpu_mem_re, cpu_mem_we, cpu_bus, dma_rd, byte_done;

    assign dma_active = (state != S_IDLE);

    // E0h-FFh would address OAM/IO; they alias echo WRAM C0h-DFh instead.
    assign src_hi = (dma_reg > 8'hDF) ? (dma_reg - 8'h20) : dma_reg;

    // Write wins over a simultaneous read, so a read is only seen with we low.
    assign reg_hit = (cpu_addr == DMA_REG_ADDR);
    assign reg_wr  = cpu_we && reg_hit;
    assign reg_rd  = cpu_re && !cpu_we && reg_hit;

`ifdef DMA_BUS_LOCK_EN
    logic hram_hit;
    assign hram_hit    = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    assign cpu_allowed = !dma_active || hram_hit;
`else
    assign cpu_allowed = 1'b1;
`endif

    // FF46 lives here and never reaches the shared bus.
    assign cpu_mem_we = cpu_we && !reg_hit && cpu_allowed;
    assign cpu_mem_re = cpu_re && !cpu_we && !reg_hit && cpu_allowed;
    assign cpu_bus    = cpu_mem_we || cpu_mem_re;

    // The CPU always has bus priority; a DMA read waits in READ for a free
    // clock (in lock mode only an HRAM access can cause that wait).
    assign dma_rd    = (state == S_READ) && !cpu_bus;
    assign byte_done = (state == S_PAD) && (pad_cnt == '0);

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        oam_addr   = 8'h00;
        oam_wdata  = 8'h00;
        oam_we     = 1'b0;

        case (state)
            S_IDLE:  if (reg_wr) state_next = S_SETUP;
            S_SETUP: state_next = S_READ;
            S_READ:  if (!cpu_bus) state_next = S_WRITE;
            S_WRITE: begin
                state_next = S_PAD;
                oam_addr   = index;
                oam_wdata  = mem_rdata;
                oam_we     = 1'b1;
            end
            S_PAD:   if (pad_cnt == '0) state_next = (index == LAST_INDEX) ? S_IDLE : S_READ;
            default: state_next = S_IDLE;
        endcase

        // A register write restarts from any state; a WRITE in this same clock
        // has already been presented on the OAM port above.
        if (reg_wr) state_next = S_SETUP;
    end

    always_comb begin
        mem_addr  = dma_rd ? {src_hi, index} : cpu_addr;
        mem_wdata = cpu_mem_we ? cpu_wdata : 8'h00;
        mem_re    = dma_rd || cpu_mem_re;
        mem_we    = cpu_mem_we;

        rd_sel_next = RD_FF;
        if (reg_rd)          rd_sel_next = RD_REG;
        else if (cpu_mem_re) rd_sel_next = RD_MEM;
    end

    always_comb begin
        case (rd_sel)
            RD_REG:  cpu_rdata = dma_reg;
            RD_MEM:  cpu_rdata = mem_rdata;
            default: cpu_rdata = 8'hFF;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_sel  <= RD_FF;
            dma_reg <= 8'h00;
            index   <= 8'h00;
            pad_cnt <= '0;
        end else begin
            state  <= state_next;
            rd_sel <= rd_sel_next;

            if (reg_wr) dma_reg <= cpu_wdata;

            // Index returns to 0 after the last byte so it never exceeds LAST_INDEX.
            if (reg_wr)         index <= 8'h00;
            else if (byte_done) index <= (index == LAST_INDEX) ? 8'h00 : index + 8'd1;

            if (state == S_WRITE)                         pad_cnt <= PAD_LOAD;
            else if ((state == S_PAD) && (pad_cnt != '0)) pad_cnt <= pad_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_controller
//
// Self-checking bench for oam_dma_controller. Idle pass-through is checked from
// a vector table; transfers are checked against a transaction-level reference:
// byte k of a transfer must be read from {src_hi,k} and written to OAM index k
// with the memory model's data, and dma_active must last 1 + 160*BYTE_CYCLES
// clocks plus at most one clock per CPU access that steals the bus.
// Works with and without DMA_BUS_LOCK_EN defined.
// -----------------------------------------------------------------------------
module tb_oam_dma_controller;

    localparam int BC     = 4;
    localparam int NB     = 160;
    localparam int T_FULL = 1 + NB * BC;
    localparam int BOUND  = 4000;

    logic        cpu_clk   = 1'b0;
    logic        rst       = 1'b1;
    logic [15:0] cpu_addr  = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_re    = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;

    oam_dma_controller #(.BYTE_CYCLES(BC), .OAM_BYTES(NB)) dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .dma_active(dma_active)
    );

    always #5 cpu_clk = ~cpu_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
    endfunction

    always @(posedge cpu_clk) mem_rdata <= mem_re ? mem_fn(mem_addr) : 8'h00;

    // Transaction monitor, sampled mid-cycle.
    logic [7:0]  oam_a_q[$];
    logic [7:0]  oam_d_q[$];
    logic [15:0] rd_q[$];
    int          active_cnt   = 0;
    int          first_we_cyc = -1;
    int          t_start      = 0;

    always begin
        @(negedge cpu_clk);
        #2;
        if (dma_active) active_cnt++;
        if (oam_we) begin
            oam_a_q.push_back(oam_addr);
            oam_d_q.push_back(oam_wdata);
            if (first_we_cyc < 0) first_we_cyc = cyc;
        end
        if (mem_re && !(cpu_re && !cpu_we && mem_addr == cpu_addr)) rd_q.push_back(mem_addr);
    end

    task automatic idle_inputs();
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    task automatic clear_logs();
        oam_a_q.delete();
        oam_d_q.delete();
        rd_q.delete();
        active_cnt   = 0;
        first_we_cyc = -1;
    endtask

    // Drives a FF46 write for one clock; inputs stay asserted until the caller's next cycle.
    task automatic start_dma(input logic [7:0] val);
        @(negedge cpu_clk);
        cpu_addr  = 16'hFF46;
        cpu_wdata = val;
        cpu_we    = 1'b1;
        cpu_re    = 1'b0;
        #1;
        check("ff46_wr_not_forwarded", mem_we, 1'b0);
        clear_logs();
        t_start = cyc;
    endtask

    // Runs until dma_active drops. rd_mode 0: CPU idle; 1: random CPU reads of
    // A0xxh; 2: CPU reads every clock for cycles t_start+2..t_start+11.
    task automatic wait_done(input int rd_mode, output int n_cpu);
        logic       pend;
        logic [7:0] pend_exp;
        int         c;
        logic       go;
        n_cpu = 0;
        pend  = 1'b0;
        pend_exp = 8'h00;
        for (c = 0; c < BOUND; c++) begin
            @(negedge cpu_clk);
            if (pend) check("cpu_rdata_during_dma", cpu_rdata, pend_exp);
            pend = 1'b0;
            idle_inputs();
            if (!dma_active) break;
            go = (rd_mode == 1 && $urandom_range(0, 3) == 0) ||
                 (rd_mode == 2 && cyc >= t_start + 2 && cyc <= t_start + 11);
            if (go) begin
                cpu_re   = 1'b1;
                cpu_addr = {8'hA0, 8'($urandom)};
                n_cpu++;
                pend = 1'b1;
                #1;
`ifdef DMA_BUS_LOCK_EN
                pend_exp = 8'hFF;
                check("cpu_rd_locked_out", mem_re && mem_addr == cpu_addr, 1'b0);
`else
                pend_exp = mem_fn(cpu_addr);
                check("cpu_rd_priority", {mem_re, mem_addr}, {1'b1, cpu_addr});
`endif
            end
        end
        check("dma_finished_in_bound", c < BOUND, 1'b1);
    endtask

    // Compares the logged transfer against the reference. 'skip' leading log
    // entries belong to an aborted earlier transfer.
    task automatic verify(input string tag, input logic [7:0] val, input int act_lo,
                          input int act_hi, input int skip, input bit chk_lat);
        logic [7:0]  src_hi;
        logic [15:0] a;
        int          n_bad_rd, n_bad_addr, n_bad_data;
        src_hi     = (val >= 8'hE0) ? val - 8'h20 : val;
        n_bad_rd   = 0;
        n_bad_addr = 0;
        n_bad_data = 0;
        check({tag, "_oam_we_count"}, oam_a_q.size(), skip + NB);
        check({tag, "_dma_read_count"}, rd_q.size(), skip + NB);
        for (int k = 0; k < NB; k++) begin
            a = {src_hi, 8'(k)};
            if (skip + k < rd_q.size() && rd_q[skip + k] !== a) n_bad_rd++;
            if (skip + k < oam_a_q.size()) begin
                if (oam_a_q[skip + k] !== 8'(k))     n_bad_addr++;
                if (oam_d_q[skip + k] !== mem_fn(a)) n_bad_data++;
            end
        end
        check({tag, "_read_addr_errors"}, n_bad_rd, 0);
        check({tag, "_oam_addr_errors"}, n_bad_addr, 0);
        check({tag, "_oam_data_errors"}, n_bad_data, 0);
        if (act_lo == act_hi) check({tag, "_active_clocks"}, active_cnt, act_lo);
        else check({tag, "_active_clocks_in_range"}, active_cnt >= act_lo && active_cnt <= act_hi, 1'b1);
        if (chk_lat) check({tag, "_first_oam_we_latency"}, first_we_cyc - t_start, 3);
    endtask

    // Waits until at least n OAM writes of the current transfer are logged.
    task automatic wait_oam_count(input int n);
        int c;
        for (c = 0; c < BOUND; c++) begin
            @(negedge cpu_clk);
            idle_inputs();
            if (oam_a_q.size() >= n) break;
        end
        check("oam_count_reached", c < BOUND, 1'b1);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        re;
        logic        we;
        logic        e_re;
        logic        e_we;
        logic        chk_rd;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n_cpu;
        logic [7:0] rv;
        int n_keep;

        vecs[0] = '{16'h1234, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mem_fn(16'h1234)};
        vecs[1] = '{16'h8000, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{16'hC123, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{16'hFFFE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mem_fn(16'hFFFE)};
        vecs[5] = '{16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mem_fn(16'h0000)};
        vecs[6] = '{16'h5555, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset state
        repeat (3) @(negedge cpu_clk);
        rst = 1'b0;
        #1;
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_oam_we", oam_we, 1'b0);
        check("rst_oam_addr", oam_addr, 8'h00);
        check("rst_dma_active", dma_active, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 8'hFF);

        // Idle pass-through vectors
        for (int i = 0; i < 7; i++) begin
            @(negedge cpu_clk);
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            cpu_re    = vecs[i].re;
            cpu_we    = vecs[i].we;
            #1;
            check($sformatf("v%0d_mem_re", i), mem_re, vecs[i].e_re);
            check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
            if (vecs[i].e_re || vecs[i].e_we) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
            if (vecs[i].e_we) check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
            check($sformatf("v%0d_dma_active", i), dma_active, 1'b0);
            @(negedge cpu_clk);
            idle_inputs();
            #1;
            if (vecs[i].chk_rd) check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
        end

        // Plain transfer from C100h
        start_dma(8'hC1);
        wait_done(0, n_cpu);
        verify("c1", 8'hC1, T_FULL, T_FULL, 0, 1'b1);

        // Echo-WRAM source and register read-back
        start_dma(8'hFE);
        wait_done(0, n_cpu);
        verify("fe", 8'hFE, T_FULL, T_FULL, 0, 1'b1);
        @(negedge cpu_clk);
        cpu_addr = 16'hFF46;
        cpu_re   = 1'b1;
        #1;
        check("ff46_rd_not_forwarded", mem_re, 1'b0);
        @(negedge cpu_clk);
        idle_inputs();
        #1;
        check("ff46_readback", cpu_rdata, 8'hFE);

        // Random sources with random CPU reads during the transfer
        for (int r = 0; r < 3; r++) begin
            rv = 8'($urandom);
            if (rv == 8'hA0) rv = 8'hA1;
            start_dma(rv);
            wait_done(1, n_cpu);
`ifdef DMA_BUS_LOCK_EN
            verify($sformatf("rnd%0d", r), rv, T_FULL, T_FULL, 0, 1'b0);
`else
            verify($sformatf("rnd%0d", r), rv, T_FULL, T_FULL + n_cpu, 0, 1'b0);
`endif
        end

        // Ten consecutive CPU reads starting at the first READ clock
        start_dma(8'hC1);
        wait_done(2, n_cpu);
`ifdef DMA_BUS_LOCK_EN
        verify("stall10", 8'hC1, T_FULL, T_FULL, 0, 1'b1);
`else
        verify("stall10", 8'hC1, T_FULL + 10, T_FULL + 10, 0, 1'b0);
`endif

        // Hand-driven CPU accesses mid-transfer
        start_dma(8'hC1);
        repeat (5) begin
            @(negedge cpu_clk);
            idle_inputs();
        end
        @(negedge cpu_clk);
        cpu_addr = 16'h8000;
        cpu_re   = 1'b1;
        #1;
`ifdef DMA_BUS_LOCK_EN
        check("mid_rd_8000_blocked", mem_re && mem_addr == 16'h8000, 1'b0);
`else
        check("mid_rd_8000_passes", {mem_re, mem_addr}, {1'b1, 16'h8000});
`endif
        @(negedge cpu_clk);
        #1;
`ifdef DMA_BUS_LOCK_EN
        check("mid_rd_8000_data", cpu_rdata, 8'hFF);
`else
        check("mid_rd_8000_data", cpu_rdata, mem_fn(16'h8000));
`endif
        cpu_re    = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = 16'hFF90;
        cpu_wdata = 8'h5A;
        #1;
        check("mid_wr_hram", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'hFF90, 8'h5A});
        @(negedge cpu_clk);
        cpu_addr  = 16'hC000;
        cpu_wdata = 8'h11;
        #1;
`ifdef DMA_BUS_LOCK_EN
        check("mid_wr_c000_dropped", mem_we, 1'b0);
`else
        check("mid_wr_c000_passes", {mem_we, mem_addr}, {1'b1, 16'hC000});
`endif
        wait_done(0, n_cpu);
        verify("mid", 8'hC1, T_FULL, T_FULL + 3, 0, 1'b1);

        // Restart at index 50 with a new source page
        start_dma(8'hC1);
        wait_oam_count(50);
        start_dma(8'h80);
        wait_done(0, n_cpu);
        verify("restart50", 8'h80, T_FULL + 1, T_FULL + 1, 0, 1'b1);

        // Restart landing on the first WRITE clock: that write still completes
        start_dma(8'hC1);
        repeat (2) begin
            @(negedge cpu_clk);
            idle_inputs();
        end
        @(negedge cpu_clk);
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'h90;
        cpu_we    = 1'b1;
        #1;
        check("restart_in_write_oam_we", {oam_we, oam_addr}, {1'b1, 8'h00});
        wait_done(0, n_cpu);
        check("restart_in_write_first_data", oam_d_q.size() > 0 ? oam_d_q[0] : 8'h00, mem_fn(16'hC100));
        verify("restart_wr", 8'h90, T_FULL + 3, T_FULL + 3, 1, 1'b1);

        // Reset at index 100
        start_dma(8'hC1);
        wait_oam_count(100);
        @(negedge cpu_clk);
        rst = 1'b1;
        @(negedge cpu_clk);
        rst = 1'b0;
        #1;
        check("rst_mid_dma_active", dma_active, 1'b0);
        check("rst_mid_cpu_rdata", cpu_rdata, 8'hFF);
        n_keep = oam_a_q.size();
        repeat (20) @(negedge cpu_clk);
        check("rst_mid_no_more_oam_we", oam_a_q.size(), n_keep);
        check("rst_mid_still_idle", dma_active, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
